color_palette: RTL and testbench

//  Avalon-MM-programmable colour lookup table: 8 palettes x 4 colours of 24-bit RGB.
//  The CPU writes entries over the Avalon slave port.
//  The pixel/sprite pipeline supplies {palette, color_index} and receives the RGB value.

---
 rtl/palette_pkg.sv | 13 +
 rtl/color_palette.sv | 35 +++
 tb/tb_color_palette.sv | 139 +++++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared sizes, colour type and entry-address helper for color_palette.
package palette_pkg;
    localparam int NUM_PALETTES   = 8;
    localparam int COLORS_PER_PAL = 4;
    localparam int RGB_W          = 24;
    localparam int PAL_W          = 3;
    localparam int IDX_W          = 2;
    localparam int ADDR_W         = 5;
    typedef logic [RGB_W-1:0] rgb_t;
    function automatic logic [ADDR_W-1:0] pal_addr(input logic [PAL_W-1:0] p, input logic [IDX_W-1:0] i);
        return {p, i};
    endfunction
endpackage

// File: rtl/color_palette.sv
// color_palette: Avalon-MM programmable 8x4 RGB lookup table with a registered pixel lookup.
module color_palette
    import palette_pkg::*;
(
    input  logic              CLK_50,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    input  logic [PAL_W-1:0]  palette,
    input  logic [IDX_W-1:0]  color_index,
    output rgb_t              rgb
);
    rgb_t mem [NUM_PALETTES*COLORS_PER_PAL];
    logic unused;
    assign unused = &{1'b0, AVL_BYTE_EN[3], AVL_WRITEDATA[31:24]};
    // Non-blocking update gives read-before-write when read and write coincide.
    always_ff @(posedge CLK_50 or posedge RESET)
        if (RESET) begin
            for (int i = 0; i < NUM_PALETTES*COLORS_PER_PAL; i++) mem[i] <= '0;
            AVL_READDATA <= '0;
        end else begin
            if (AVL_CS && AVL_WRITE)
                for (int b = 0; b < 3; b++)
                    if (AVL_BYTE_EN[b]) mem[AVL_ADDR][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
            if (AVL_CS && AVL_READ) AVL_READDATA <= {8'h00, mem[AVL_ADDR]};
        end
    always_ff @(posedge CLK_50 or posedge RESET)
        if (RESET) rgb <= '0;
        else rgb <= mem[pal_addr(palette, color_index)];
endmodule

// File: tb/tb_color_palette.sv
// tb_color_palette: directed table-driven checks of color_palette bus access and pixel lookup.
module tb_color_palette;
    logic        clk = 0, rst = 1, cs = 0, rd_en = 0, wr_en = 0;
    logic [4:0]  addr = 0;
    logic [3:0]  be = 0;
    logic [31:0] wdata = 0, rdata, q;
    logic [2:0]  pal = 0;
    logic [1:0]  idx = 0;
    logic [23:0] rgb;
    int n_checks = 0, n_errors = 0;
    typedef struct { logic [2:0] pal; logic [1:0] idx; logic [23:0] exp; } lk_vec_t;
    typedef struct { logic [4:0] addr; logic [31:0] exp; } rd_vec_t;
    lk_vec_t lk [8];
    rd_vec_t rv [8];
    always #5 clk = ~clk;
    color_palette dut (
        .CLK_50(clk), .RESET(rst), .AVL_CS(cs), .AVL_READ(rd_en), .AVL_WRITE(wr_en),
        .AVL_ADDR(addr), .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata), .AVL_READDATA(rdata),
        .palette(pal), .color_index(idx), .rgb(rgb)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b, input logic c = 1);
        @(negedge clk);
        cs = c; wr_en = 1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 0; wr_en = 0;
    endtask
    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        cs = 1; rd_en = 1; addr = a;
        @(negedge clk);
        v = rdata;
        cs = 0; rd_en = 0;
    endtask
    task automatic look(input logic [2:0] p, input logic [1:0] i, input logic [23:0] exp, input string name);
        @(negedge clk);
        pal = p; idx = i;
        @(negedge clk);
        chk(name, {8'h0, rgb}, {8'h0, exp});
    endtask
    initial begin
        lk[0] = '{3'd0, 2'd0, 24'h000000};
        lk[1] = '{3'd0, 2'd1, 24'hFF0000};
        lk[2] = '{3'd0, 2'd2, 24'h00FF00};
        lk[3] = '{3'd0, 2'd3, 24'hFFFFFF};
        lk[4] = '{3'd2, 2'd0, 24'h0000FF};
        lk[5] = '{3'd0, 2'd0, 24'h000000};
        lk[6] = '{3'd1, 2'd1, 24'hBB00DD};
        lk[7] = '{3'd7, 2'd3, 24'h123456};
        rv[0] = '{5'd0,  32'h00000000};
        rv[1] = '{5'd1,  32'h00FF0000};
        rv[2] = '{5'd2,  32'h0000FF00};
        rv[3] = '{5'd3,  32'h00FFFFFF};
        rv[4] = '{5'd5,  32'h00BB00DD};
        rv[5] = '{5'd8,  32'h000000FF};
        rv[6] = '{5'd31, 32'h00123456};
        rv[7] = '{5'd4,  32'h00000000};
        #1;
        chk("reset_rgb", {8'h0, rgb}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        // Write attempted during reset must be dropped.
        wr(5'd3, 32'h00ABCDEF, 4'hF);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], q);
            chk($sformatf("reset_entry%0d", i), q, 32'h0);
        end
        chk("reset_rgb_after", {8'h0, rgb}, 32'h0);
        wr(5'd0, 32'h00000000, 4'hF);
        wr(5'd1, 32'h00FF0000, 4'hF);
        wr(5'd2, 32'h0000FF00, 4'hF);
        wr(5'd3, 32'h00FFFFFF, 4'hF);
        wr(5'd5, 32'hAABBCCDD, 4'b0101);
        rd(5'd5, q);
        chk("byte_en_0101", q, 32'h00BB00DD);
        wr(5'd5, 32'h11223344, 4'b1000);
        rd(5'd5, q);
        chk("byte_en3_ignored", q, 32'h00BB00DD);
        wr(5'd31, 32'h00123456, 4'hF, 1'b0);
        rd(5'd31, q);
        chk("cs_gated_write", q, 32'h0);
        wr(5'd31, 32'h00123456, 4'hF);
        rd(5'd31, q);
        chk("cs_write", q, 32'h00123456);
        @(negedge clk);
        cs = 0; rd_en = 1; addr = 5'd0;
        @(negedge clk);
        rd_en = 0;
        chk("cs_gated_read_hold", rdata, 32'h00123456);
        wr(5'd8, 32'h000000FF, 4'hF);
        for (int i = 0; i < 8; i++)
            look(lk[i].pal, lk[i].idx, lk[i].exp, $sformatf("lookup%0d", i));
        for (int i = 0; i < 8; i++) begin
            rd(rv[i].addr, q);
            chk($sformatf("readback_addr%0d", rv[i].addr), q, rv[i].exp);
        end
        // Simultaneous read and write returns old contents.
        @(negedge clk);
        cs = 1; rd_en = 1; wr_en = 1; addr = 5'd1; wdata = 32'h00ABCDEF; be = 4'hF;
        @(negedge clk);
        cs = 0; rd_en = 0; wr_en = 0;
        chk("rbw_old", rdata, 32'h00FF0000);
        @(negedge clk);
        chk("rdata_hold", rdata, 32'h00FF0000);
        rd(5'd1, q);
        chk("rbw_new", q, 32'h00ABCDEF);
        look(3'd0, 2'd2, 24'h00FF00, "collide_pre");
        @(negedge clk);
        cs = 1; wr_en = 1; addr = 5'd2; wdata = 32'h00010203; be = 4'hF;
        @(negedge clk);
        cs = 0; wr_en = 0;
        chk("collide_old", {8'h0, rgb}, 32'h0000FF00);
        @(negedge clk);
        chk("collide_new", {8'h0, rgb}, 32'h00010203);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("async_rgb", {8'h0, rgb}, 32'h0);
        chk("async_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_reset_rgb", {8'h0, rgb}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], q);
            chk($sformatf("post_reset_entry%0d", i), q, 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
